crc_checker: RTL
================

CRC_CHECKER -- requirements
Module: crc_checker

Interface
REQ-001 Parameter: WIDTH, 8, number of data bits and CRC bits per frame.
REQ-002 Parameter: SEED, 8'hD8, LFSR value loaded at reset and at every frame start.
REQ-003 Parameter: TAPS, 8'h44, feedback tap mask matching the team's serial CRC generator.
REQ-004 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: RST  input  1  asynchronous, active-low reset.
REQ-006 Port: data  input  1  serial frame data, LSB first, sampled while active=1.
REQ-007 Port: active  input  1  data-phase qualifier from the generator.
REQ-008 Port: crc  input  1  serial received CRC, LSB first, sampled while valid=1.
REQ-009 Port: valid  input  1  CRC-phase qualifier from the generator.
REQ-010 Port: rx_data  output  WIDTH  received data byte, updated at frame end.
REQ-011 Port: done  output  1  one-cycle pulse marking the end of a frame (check or abort).
REQ-012 Port: crc_ok  output  1  CRC matched; valid only while done=1.
REQ-013 Port: crc_err  output  1  CRC mismatch or framing abort; valid only while done=1.

Function
REQ-014 FSM states: IDLE, DATA, CHECK, REPORT; the FSM SHALL leave IDLE only on active=1.
REQ-015 Frame-start edge: on the first edge with active=1 in IDLE, the LFSR loads SEED, bit 0 is shifted in, and bit_cnt is set to 1.
REQ-016 DATA update, per edge with active=1: fb = data ^ lfsr[0]; lfsr[WIDTH-1] <= fb; lfsr[i] <= TAPS[i] ? lfsr[i+1]^fb : lfsr[i+1]; data is shifted into a shift register LSB first; bit_cnt increments.
REQ-017 Transition DATA->CHECK: taken after WIDTH data bits; the next valid=1 edge starts the comparison.
REQ-018 CHECK compare, per edge with valid=1: crc is compared with lfsr[0]; any mismatch sets a sticky mismatch flag; lfsr shifts right (zero fill); bit_cnt increments.
REQ-019 Transition CHECK->REPORT: taken after WIDTH CRC bits; in REPORT, done=1 for exactly one cycle; crc_ok=!mismatch; crc_err=mismatch; rx_data loads the shift register; the FSM then returns to IDLE.
REQ-020 Latency: done asserts on the edge after the last CRC bit is sampled.
REQ-021 Abort in DATA: active falling before WIDTH bits causes the REPORT path with crc_err=1 and rx_data unchanged.
REQ-022 Abort in CHECK: valid falling before WIDTH CRC bits, or active rising, causes the REPORT path with crc_err=1.
REQ-023 Inter-phase gap: the gap between DATA and CHECK (active=0, valid=0) SHALL be at most 2 cycles; a longer gap aborts the frame with crc_err=1.
REQ-024 valid=1 while in IDLE SHALL be ignored with no done pulse.
REQ-025 Back-to-back frames: active=1 in the REPORT cycle starts a new frame on the next edge without loss.
REQ-026 Mutual exclusion: crc_ok and crc_err SHALL never both be 1, and both SHALL be 0 whenever done=0.

Reset
REQ-027 RST=0 asynchronously forces: FSM=IDLE, lfsr=SEED, bit_cnt=0, mismatch=0, rx_data=0, done=0, crc_ok=0, crc_err=0.
REQ-028 Reset asserted mid-frame SHALL discard the frame with no done pulse.
REQ-029 After reset release, the first frame SHALL be accepted on the first edge with active=1.

Configuration
REQ-030 Macro: CRC_ERR_CNT_EN.
REQ-031 Defined: add output err_cnt [7:0], which increments on each done with crc_err=1, saturates at 8'hFF, and resets to 0.
REQ-032 Undefined: port err_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-033 Good frames: the bench drives frames 0x93/0x78, 0x72/0x44, 0x36/0x11, 0x1B/0xD2 and 0xA6/0x09 directly from the generator; each frame requires done with crc_ok=1 and rx_data equal to the data byte.
REQ-034 Corrupted CRC: data 0x93 with CRC 0x79 (bit 0 flipped) requires done with crc_err=1 and rx_data=0x93.
REQ-035 Short frame: active held high for 5 bits then dropped requires done with crc_err=1 and rx_data unchanged.
REQ-036 Reset mid-frame: RST=0 during the 3rd CRC bit requires all outputs to be 0 immediately, no done pulse, and a correct pass on the next 0x72/0x44 frame.
REQ-037 Stray valid: valid pulsed for 8 cycles in IDLE requires no done pulse; back-to-back frames 0x36 then 0x1B both require crc_ok=1.
REQ-038 Error counter: with CRC_ERR_CNT_EN defined, 3 bad frames require err_cnt=3, and 300 bad frames require err_cnt=0xFF.

Source files
------------

// File: rtl/crc_checker.sv
// Serial LSB-first CRC checker: an LFSR runs over the data bits, then each received CRC bit is compared with it.
// Define CRC_ERR_CNT_EN to add the saturating err_cnt output that counts erroneous frames.
module crc_checker #(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = 8'hD8,
   parameter logic [WIDTH-1:0] TAPS  = 8'h44
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             data,
   input  logic             active,
   input  logic             crc,
   input  logic             valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             done,
   output logic             crc_ok,
   output logic             crc_err
`ifdef CRC_ERR_CNT_EN
   ,
   output logic [7:0]       err_cnt
`endif
);

   localparam int unsigned      CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, DATA, CHECK, REPORT} state_t;

   state_t           state;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic [1:0]       gap_cnt;
   logic             mismatch;
   logic             bit_miss;

   assign bit_miss = crc ^ lfsr[0];

   // One serial step: feedback enters at the MSB and is XORed into every tapped position.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur, input logic din);
      logic fb;
      fb = din ^ cur[0];
      return {fb, cur[WIDTH-1:1] ^ (TAPS[WIDTH-2:0] & {(WIDTH-1){fb}})};
   endfunction

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         lfsr     <= SEED;
         shreg    <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         mismatch <= 1'b0;
         rx_data  <= '0;
         done     <= 1'b0;
         crc_ok   <= 1'b0;
         crc_err  <= 1'b0;
      end else begin
         // NOTE: status outputs default low every edge, so done/crc_ok/crc_err can only be high for the single REPORT cycle.
         done    <= 1'b0;
         crc_ok  <= 1'b0;
         crc_err <= 1'b0;
         case (state)
            IDLE, REPORT: begin
               if (active) begin
                  lfsr     <= lfsr_step(SEED, data);
                  shreg    <= {data, shreg[WIDTH-1:1]};
                  bit_cnt  <= CNT_W'(1);
                  mismatch <= 1'b0;
                  state    <= DATA;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (active) begin
                  lfsr  <= lfsr_step(lfsr, data);
                  shreg <= {data, shreg[WIDTH-1:1]};
                  if (bit_cnt == LAST) begin
                     state   <= CHECK;
                     bit_cnt <= '0;
                     gap_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else begin
                  state   <= REPORT;
                  done    <= 1'b1;
                  crc_err <= 1'b1;
               end
            end
            CHECK: begin
               // Abort on a new frame, on valid dropping mid-CRC, or on a third idle gap cycle.
               if (active || (!valid && (bit_cnt != '0 || gap_cnt == 2'd2))) begin
                  state   <= REPORT;
                  done    <= 1'b1;
                  crc_err <= 1'b1;
               end else if (valid) begin
                  lfsr <= lfsr >> 1;
                  if (bit_cnt == LAST) begin
                     state   <= REPORT;
                     done    <= 1'b1;
                     crc_ok  <= !(mismatch | bit_miss);
                     crc_err <= mismatch | bit_miss;
                     rx_data <= shreg;
                  end else begin
                     mismatch <= mismatch | bit_miss;
                     bit_cnt  <= bit_cnt + CNT_W'(1);
                  end
               end else begin
                  gap_cnt <= gap_cnt + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CRC_ERR_CNT_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         err_cnt <= '0;
      end else if (done && crc_err && err_cnt != 8'hFF) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule
